// File: rtl/mavg_pkg.sv
// Shared types and helpers for the moving-average filter slice.
package mavg_pkg;

    // Window state: FILL while fewer than DEPTH samples are held, RUN afterwards.
    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } mavg_state_t;

    // Ceiling log2, usable for elaboration-time constants.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Half-LSB bias added before dropping `shift` fractional bits.
    function automatic int round_offset(input int shift);
        return (shift > 0) ? (1 << (shift - 1)) : 0;
    endfunction

endpackage

// File: rtl/mavg_delay_line.sv
// Zero-resettable ring buffer holding the last DEPTH samples of the window.
// dout_old is the slot about to be overwritten, read before the write lands.
module mavg_delay_line
    import mavg_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     we,
    input  logic signed [DATA_W-1:0] din,
    output logic signed [DATA_W-1:0] dout_old
);

    localparam int L = clog2(DEPTH);

    logic signed [DATA_W-1:0] ring_q [DEPTH];
    logic        [L-1:0]      wp_q;

    // The pointer is exactly L bits wide, so it wraps DEPTH-1 -> 0 for free.
    assign dout_old = ring_q[wp_q];

    // Write the new sample over the oldest one and advance the pointer.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ring_q[i] <= '0;
            end
            wp_q <= '0;
        end else if (we) begin
            ring_q[wp_q] <= din;
            wp_q         <= wp_q + 1'b1;
        end
    end

endmodule

// File: rtl/moving_average_n.sv
// DEPTH-tap moving-average filter: running window sum with a ring buffer,
// rounded mean output and a primed flag once a full window has been seen.
module moving_average_n
    import mavg_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     enable_n,
    input  logic                     clear,
    input  logic signed [DATA_W-1:0] X,
    output logic signed [DATA_W-1:0] Z,
    output logic                     Z_valid,
    output logic                     primed
);

    localparam int L     = clog2(DEPTH);
    localparam int ACC_W = DATA_W + L;

    localparam logic signed [ACC_W:0] RND_OFS   = (ACC_W + 1)'(round_offset(L));
    localparam logic        [L:0]     FILL_LAST = (L + 1)'(DEPTH - 1);
    localparam logic        [L:0]     FILL_FULL = (L + 1)'(DEPTH);

    // Round half toward +inf, then divide by DEPTH with an arithmetic shift.
    // The mean of in-range samples always fits DATA_W, so no saturation.
    function automatic logic signed [DATA_W-1:0] round_mean(input logic signed [ACC_W:0] sum);
        logic signed [ACC_W:0] biased;
        logic signed [ACC_W:0] shifted;
        biased  = sum + RND_OFS;
        shifted = biased >>> L;
        return shifted[DATA_W-1:0];
    endfunction

    logic flush;
    logic accept;

    logic signed [DATA_W-1:0] old;
    logic signed [ACC_W-1:0]  acc_p0;
    logic signed [ACC_W:0]    acc_ext;
    logic signed [ACC_W:0]    x_ext;
    logic signed [ACC_W:0]    old_ext;
    logic signed [ACC_W:0]    acc_sum;

    logic signed [DATA_W-1:0] z_p0;
    logic                     vld_p0;
    logic                     primed_p0;

    mavg_state_t state_q, state_d;
    logic [L:0]  fill_q, fill_d;
    logic        run_next;

    // Clear behaves like reset and wins over a coincident strobe.
    assign flush  = Rst | clear;
    assign accept = ~enable_n & ~flush;

    mavg_delay_line #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_delay_line (
        .Clk      (Clk),
        .Rst      (flush),
        .we       (accept),
        .din      (X),
        .dout_old (old)
    );

    // One guard bit keeps acc + X - old exact before it is narrowed back.
    assign acc_ext = {acc_p0[ACC_W-1], acc_p0};
    assign x_ext   = {{(L + 1){X[DATA_W-1]}}, X};
    assign old_ext = {{(L + 1){old[DATA_W-1]}}, old};
    assign acc_sum = acc_ext + x_ext - old_ext;

    // Next-state logic: the accept that completes the window moves FILL -> RUN.
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        if (accept) begin
            if (fill_q != FILL_FULL) begin
                fill_d = fill_q + 1'b1;
            end
            case (state_q)
                FILL:    if (fill_q == FILL_LAST) state_d = RUN;
                RUN:     state_d = RUN;
                default: state_d = FILL;
            endcase
        end
    end

    assign run_next = accept & (state_d == RUN);

    // FSM state and fill counter registers.
    always_ff @(posedge Clk) begin
        if (flush) begin
            state_q <= FILL;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
        end
    end

    // Stage p0: accumulator and rounded mean, updated on each accept.
    always_ff @(posedge Clk) begin
        if (flush) begin
            acc_p0 <= '0;
            z_p0   <= '0;
        end else if (accept) begin
            acc_p0 <= acc_sum[ACC_W-1:0];
            z_p0   <= round_mean(acc_sum);
        end
    end

    // Valid pulse and sticky primed flag, registered alongside Z.
    always_ff @(posedge Clk) begin
        if (flush) begin
            vld_p0    <= 1'b0;
            primed_p0 <= 1'b0;
        end else begin
            vld_p0    <= run_next;
            primed_p0 <= primed_p0 | run_next;
        end
    end

    assign Z       = z_p0;
    assign Z_valid = vld_p0;
    assign primed  = primed_p0;

endmodule

// File: doc/moving_average_n.md
# moving_average_n

Parametrised N-tap moving-average filter, the next generation of the fixed 3-tap sample filter in the data path. It accepts one signed sample per strobe and keeps a running window sum in a ring buffer: each sample adds the new value and subtracts the oldest. It outputs the rounded mean of the last DEPTH samples and flags when the window is fully primed. It sits between the sample source and downstream consumers, using the same active-low sample strobe.

## Interface
- DATA_W, 8: sample and result width, signed two's complement, 4..16.
- DEPTH, 8: window length; power of two, 2..64.
- Clk  input  1  rising-edge clock; the only clock.
- Rst  input  1  reset; synchronous and active-high.
- enable_n  input  1  active-low sample strobe; X is accepted on each Clk edge where it is low.
- clear  input  1  synchronous history clear; same effect as Rst.
- X  input  DATA_W  signed input sample.
- Z  output  DATA_W  signed rounded window mean.
- Z_valid  output  1  one-cycle pulse: Z holds the mean of a full window.
- primed  output  1  high once DEPTH samples have been accepted since the last reset or clear.

## Operation
- Internal constants and storage:
  - L = log2(DEPTH).
  - Accumulator `acc` is signed, DATA_W+L bits.
  - Ring buffer of DEPTH x DATA_W registers with write pointer `wp` (L bits).
  - Fill counter `fill` (0..DEPTH).
  - Two-state FSM: FILL, RUN.
- Accepted sample (enable_n=0, Rst=0, clear=0):
  - `old` = buf[wp]. `acc_n` = acc + X - old, computed at full width with no wrap.
  - buf[wp] <= X; wp <= wp+1, wrapping DEPTH-1 -> 0.
  - acc <= acc_n.
  - Z <= (acc_n + 2^(L-1)) >>> L, i.e. round half toward +inf with an arithmetic shift.
- Saturation: none needed. The mean of in-range samples stays in range: all-max gives 2^(DATA_W-1)-1 and all-min gives -2^(DATA_W-1).
- FILL state:
  - Unfilled history slots read as zero, so Z is the partial sum divided by DEPTH.
  - Z_valid stays low.
  - fill increments per accepted sample. On the accept that makes fill reach DEPTH, go to RUN; that same accept produces the first Z_valid pulse.
- RUN state: every accepted sample pulses Z_valid on the following cycle. fill saturates at DEPTH.
- No accept (enable_n=1): all state, Z and primed hold; Z_valid = 0.
- Rst or clear:
  - Buffer, acc, wp, fill and Z go to 0; state goes to FILL.
  - Z_valid and primed go to 0.
  - A simultaneous strobe is dropped, i.e. clear/Rst wins.
- Reset mid-window discards the partial history. No sample from before the reset contributes to any later Z.

## Timing
- Values after Rst: Z=0, Z_valid=0, primed=0.
- Latency: Z is registered and updates on the Clk edge that accepts X, so it is visible the cycle after the strobe.
- Z_valid is registered alongside Z and lasts exactly one cycle per accepted sample in RUN.
- primed rises on the same edge as the first Z_valid and stays high until Rst or clear.
- Throughput: one sample per cycle, including back-to-back strobes. Gaps of any length are allowed.
- wp wrap is seamless: the accept at wp=DEPTH-1 is followed by an accept at wp=0 with no bubble.

## Structure
- Shared package `mavg_pkg`:
  - clog2 function.
  - State enum {FILL, RUN}.
  - Rounding-offset constant helper.
- Sub-module `mavg_delay_line`, parameters DATA_W and DEPTH:
  - Zero-resettable ring buffer with write pointer.
  - Ports: Clk, Rst (OR-ed with clear), we, din, and dout_old (combinational read at the pointer before the write).
- Top level holds the accumulator, FSM, fill counter and output registers.

## Test plan
All scenarios use the default parameters (DATA_W=8, DEPTH=8).
- Prime: after Rst, 8 back-to-back samples of 16 -> Z=2,4,6,...,14 with Z_valid=0, then Z=16 with Z_valid=1 and primed=1 after the 8th sample.
- Step down: from the primed-at-16 state, 8 samples of -16 -> Z=12,8,4,0,-4,-8,-12,-16, each with a Z_valid pulse.
- Rounding and sign: after clear, single samples (window otherwise zero) give:
  - X=3 -> 0
  - X=4 -> 1 (half rounds up)
  - X=-4 -> 0
  - X=-5 -> -1
- Extremes: 8 samples of 127 -> Z=127; then 8 samples of -128 -> Z=-128. No wrap occurs.
- Gapped strobes: samples 10,20,30,... with 0-5 idle cycles between them.
  - Z and primed hold during gaps; Z_valid is low during gaps.
  - Z matches a reference model per accept across at least 3 pointer wraps.
- Clear collision: in RUN, assert clear together with enable_n=0 and X=100.
  - Next cycle: Z=0, primed=0, Z_valid=0.
  - The next accepted sample of 8 gives Z=1.
